// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line-level constants shared by the UART transmitter and receiver.
// Rev 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter; tick marks the last clk cycle of each bit while enabled.
// Rev 1.0
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int TW = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else if (!en || (tick_cnt_q == LAST_TICK)) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  assign tick = en && (tick_cnt_q == LAST_TICK);

endmodule

`default_nettype wire

// File: rtl/transmitter1_uart_fsm.sv
// transmitter1_uart_fsm: serialises one byte into a start/data(LSB first)/stop UART frame.
// Rev 1.0
`default_nettype none

module transmitter1_uart_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              start,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_e       state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  // tx is updated together with the state so the line value is always a flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q      <= STOP_BIT;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
          if (start) begin
            shift_q <= din;
            tx_q    <= START_BIT;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= STOP;
              tx_q    <= STOP_BIT;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= STOP_BIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_transmitter1_uart_fsm.sv
// tb_transmitter1_uart_fsm: directed and randomized frame checks at CLKS_PER_BIT=1 and 4.
// Rev 1.0
`default_nettype none

module tb_transmitter1_uart_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din1, din4;
  logic       start1, start4;
  logic       tx1, busy1, done1;
  logic       tx4, busy4, done4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  transmitter1_uart_fsm #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .din(din1), .start(start1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  transmitter1_uart_fsm #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .din(din4), .start(start4),
    .tx(tx4), .busy(busy4), .done(done4)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_in(input int s, input logic st, input logic [7:0] d);
    if (s == 0) begin start1 = st; din1 = d; end
    else        begin start4 = st; din4 = d; end
  endtask

  function automatic logic [2:0] obs(input int s);
    return (s == 0) ? {tx1, busy1, done1} : {tx4, busy4, done4};
  endfunction

  // Line value for frame bit b: start, data LSB first, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0)      return 1'b0;
    else if (b <= 8) return d[b-1];
    else             return 1'b1;
  endfunction

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_tx"},   32'(obs(s)[2]), 32'd1);
    chk({tag, "_busy"}, 32'(obs(s)[1]), 32'd0);
    chk({tag, "_done"}, 32'(obs(s)[0]), 32'd0);
  endtask

  // Called one step after the accepting edge; returns in the done cycle.
  // mode 0: inputs untouched, 1: random din/start every cycle, 2: one start with 8'h55 at cycle 3.
  task automatic check_frame(input int s, input logic [7:0] d, input int cpb, input int mode);
    logic [7:0] rec;
    int b;
    rec = 8'h00;
    for (int i = 0; i < 10 * cpb; i++) begin
      b = i / cpb;
      chk("frame_tx",   32'(obs(s)[2]), 32'(exp_bit(d, b)));
      chk("frame_busy", 32'(obs(s)[1]), 32'd1);
      chk("frame_done", 32'(obs(s)[0]), 32'd0);
      if (b >= 1 && b <= 8 && (i % cpb) == cpb / 2) rec[b-1] = obs(s)[2];
      if (mode == 1) set_in(s, 1'($urandom_range(0, 1)), 8'($urandom));
      else if (mode == 2) begin
        if (i == 3) set_in(s, 1'b1, 8'h55);
        else        set_in(s, 1'b0, 8'h55);
      end
      tick();
    end
    chk("end_done", 32'(obs(s)[0]), 32'd1);
    chk("end_busy", 32'(obs(s)[1]), 32'd0);
    chk("end_tx",   32'(obs(s)[2]), 32'd1);
    chk("loopback", 32'(rec), 32'(d));
  endtask

  initial begin
    logic [7:0] data, nxt;
    int cpb;

    // Reset held with start asserted.
    rst_n = 1'b0;
    set_in(0, 1'b1, 8'hC3);
    set_in(1, 1'b1, 8'hC3);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle(0, "rst1");
      chk_idle(1, "rst4");
    end
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick();
    chk_idle(0, "post_rst");

    // Single frame 8'hC3.
    set_in(0, 1'b1, 8'hC3);
    tick();
    set_in(0, 1'b0, 8'hC3);
    check_frame(0, 8'hC3, 1, 0);
    tick();
    chk_idle(0, "after_c3");

    // Start while busy is ignored.
    set_in(0, 1'b1, 8'hC3);
    tick();
    check_frame(0, 8'hC3, 1, 2);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_idle(0, "no_second");
    end

    // Back-to-back with start held high.
    set_in(0, 1'b1, 8'hA5);
    tick();
    check_frame(0, 8'hA5, 1, 0);
    set_in(0, 1'b1, 8'h3C);
    tick();
    check_frame(0, 8'h3C, 1, 0);
    set_in(0, 1'b0, 8'h00);
    tick();
    chk_idle(0, "after_b2b");

    // Four clocks per bit.
    set_in(1, 1'b1, 8'h01);
    tick();
    set_in(1, 1'b0, 8'h01);
    check_frame(1, 8'h01, 4, 0);
    tick();
    chk_idle(1, "after_01");

    // Reset during data bit 3 of 8'h96 (bit 3 is 0).
    set_in(1, 1'b1, 8'h96);
    tick();
    set_in(1, 1'b0, 8'h96);
    for (int i = 0; i < 17; i++) tick();
    chk("bit3_tx", 32'(tx4), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tx",   32'(tx4),   32'd1);
    chk("async_busy", 32'(busy4), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle(1, "midrst");
    end
    rst_n = 1'b1;
    tick();
    chk_idle(1, "midrst_rel");
    set_in(1, 1'b1, 8'hFF);
    tick();
    set_in(1, 1'b0, 8'hFF);
    check_frame(1, 8'hFF, 4, 0);
    tick();
    chk_idle(1, "after_ff");

    // Randomized frames, noisy inputs while busy, random back-to-back.
    for (int s = 0; s < 2; s++) begin
      cpb  = (s == 0) ? 1 : 4;
      data = 8'($urandom);
      set_in(s, 1'b1, data);
      tick();
      for (int k = 0; k < 6; k++) begin
        check_frame(s, data, cpb, 1);
        nxt = 8'($urandom);
        if (k < 5 && $urandom_range(0, 1) == 1) begin
          set_in(s, 1'b1, nxt);
          tick();
          data = nxt;
        end else begin
          set_in(s, 1'b0, nxt);
          tick();
          chk_idle(s, "rnd_gap");
          if (k < 5) begin
            set_in(s, 1'b1, nxt);
            tick();
            data = nxt;
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
